// File: rtl/magic_serial_adder.sv
// Bit-serial adder/subtractor, one bit per cycle, LSB first.
// Per-bit sum/carry logic uses only 2-input NOR and NOT primitives.
module magic_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  function automatic logic g_nor(input logic x, input logic y);
    return ~(x | y);
  endfunction

  function automatic logic g_not(input logic x);
    return ~x;
  endfunction

  function automatic logic g_xor(input logic x, input logic y);
    logic n;
    logic p;
    logic q;
    n = g_nor(x, y);
    p = g_nor(x, n);
    q = g_nor(y, n);
    return g_not(g_nor(p, q));
  endfunction

  function automatic logic g_and(input logic x, input logic y);
    return g_nor(g_not(x), g_not(y));
  endfunction

  function automatic logic g_or(input logic x, input logic y);
    return g_not(g_nor(x, y));
  endfunction

  function automatic logic g_maj(
    input logic x,
    input logic y,
    input logic c
  );
    return g_or(g_and(x, y), g_and(c, g_xor(x, y)));
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             bit_a;
  logic             bit_b;
  logic             bit_s;
  logic             carry_nxt;
  logic [WIDTH-1:0] shreg_nxt;

  always_comb begin
    bit_a     = a_q[idx_q];
    bit_b     = g_xor(b_q[idx_q], sub_q);
    bit_s     = g_xor(g_xor(bit_a, bit_b), carry_q);
    carry_nxt = g_maj(bit_a, bit_b, carry_q);
    shreg_nxt = {bit_s, shreg_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        shreg_d = shreg_nxt;
        carry_d = carry_nxt;
        if (idx_q == LAST) begin
          idx_d   = '0;
          sum_d   = shreg_nxt;
          cout_d  = carry_nxt;
          // carry_q here is the carry into the MSB
          ovf_d   = g_xor(carry_q, carry_nxt);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      shreg_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
